// File: rtl/add_tree_join.sv
// N-channel joining adder: one word from every channel per transfer, each
// optionally negated, summed by a pipelined binary tree behind a valid/ready output.
module add_tree_join #(
    parameter int DATA_W = 16,
    parameter int CH_N   = 4,
    parameter int SIGNED = 0,
    localparam int LEVELS = $clog2(CH_N),
    localparam int OUT_W  = DATA_W + LEVELS + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_N*DATA_W-1:0]   dinp,
    input  logic [CH_N-1:0]          in_valid,
    output logic [CH_N-1:0]          in_ready,
    input  logic [CH_N-1:0]          sub_mask,
    output logic [OUT_W-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              xfer_cnt
);

    localparam int LEAVES = 1 << LEVELS;

    // Handshake: a word moves on a channel only when valid and ready are both
    // high at posedge clk. Inputs join: every in_ready bit is the same signal,
    // so all channels transfer together or none do. The output follows the
    // usual rule: out/out_valid hold until out_ready is seen with out_valid.
    logic ce;
    logic all_valid;
    logic xfer;

    // stage_q[l] is the registered level l of the tree; stage_d is its next value.
    logic [OUT_W-1:0] stage_q [LEVELS+1][LEAVES];
    logic [OUT_W-1:0] stage_d [LEVELS+1][LEAVES];
    logic [LEVELS:0]  stage_vld;

    assign all_valid = &in_valid;
    assign ce        = out_ready | ~stage_vld[LEVELS];
    assign xfer      = ce & all_valid & ~rst;
    assign in_ready  = {CH_N{xfer}};

    // Leaves: extend, then negate where the mask asks; padding leaves stay zero.
    for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
        if (g < CH_N) begin : g_used
            logic [DATA_W-1:0] word;
            logic [OUT_W-1:0]  ext;
            assign word = dinp[g*DATA_W +: DATA_W];
            if (SIGNED != 0) begin : g_sext
                assign ext = {{(OUT_W-DATA_W){word[DATA_W-1]}}, word};
            end else begin : g_zext
                assign ext = {{(OUT_W-DATA_W){1'b0}}, word};
            end
            assign stage_d[0][g] = sub_mask[g] ? ('0 - ext) : ext;
        end else begin : g_pad
            assign stage_d[0][g] = '0;
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        for (genvar i = 0; i < LEAVES; i++) begin : g_node
            if (i < (LEAVES >> l)) begin : g_sum
                assign stage_d[l][i] = stage_q[l-1][2*i] + stage_q[l-1][2*i+1];
            end else begin : g_idle
                assign stage_d[l][i] = '0;
            end
        end
    end

    // The whole pipe moves in lock-step on ce; a stall freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            xfer_cnt  <= '0;
            for (int l = 0; l <= LEVELS; l++) begin
                for (int i = 0; i < LEAVES; i++) begin
                    stage_q[l][i] <= '0;
                end
            end
        end else begin
            if (stage_vld[LEVELS] && out_ready) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            if (ce) begin
                stage_vld <= {stage_vld[LEVELS-1:0], xfer};
                stage_q   <= stage_d;
            end
        end
    end

    assign out       = stage_q[LEVELS][0];
    assign out_valid = stage_vld[LEVELS];

endmodule

// File: tb/tb_add_tree_join.sv
// Bench for add_tree_join: three instances (unsigned 4-ch, signed 4-ch, unsigned 3-ch)
// share stimulus; a per-instance expected queue is fed by an arithmetic reference model.
module tb_add_tree_join;

    localparam int OW = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dinp = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  sub_mask = '0;
    logic        out_ready = 1'b1;

    logic [3:0]    in_ready_a, in_ready_b;
    logic [2:0]    in_ready_c;
    logic [OW-1:0] out_a, out_b, out_c;
    logic          ov_a, ov_b, ov_c;
    logic [31:0]   cnt_a, cnt_b, cnt_c;

    int errors = 0;
    int checks = 0;
    int n_out_a = 0;
    bit prev_stall = 1'b0;
    logic [OW-1:0] prev_out = '0;
    bit bp_on = 1'b0;
    int bp_cnt = 0;

    logic [OW-1:0] exp_qa[$];
    logic [OW-1:0] exp_qb[$];
    logic [OW-1:0] exp_qc[$];

    always #5 clk = ~clk;

    add_tree_join #(.DATA_W(8), .CH_N(4), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .dinp(dinp), .in_valid(in_valid), .in_ready(in_ready_a),
        .sub_mask(sub_mask), .out(out_a), .out_valid(ov_a), .out_ready(out_ready),
        .xfer_cnt(cnt_a)
    );

    add_tree_join #(.DATA_W(8), .CH_N(4), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .dinp(dinp), .in_valid(in_valid), .in_ready(in_ready_b),
        .sub_mask(sub_mask), .out(out_b), .out_valid(ov_b), .out_ready(out_ready),
        .xfer_cnt(cnt_b)
    );

    add_tree_join #(.DATA_W(8), .CH_N(3), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst), .dinp(dinp[23:0]), .in_valid(in_valid[2:0]),
        .in_ready(in_ready_c), .sub_mask(sub_mask[2:0]), .out(out_c), .out_valid(ov_c),
        .out_ready(out_ready), .xfer_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed sum of the first ch channels, then truncated to OW bits.
    function automatic logic [OW-1:0] model(input logic [31:0] d, input logic [3:0] m,
                                            input int ch, input bit sgn);
        longint s;
        longint v;
        logic [7:0] w;
        s = 0;
        for (int i = 0; i < ch; i++) begin
            w = d[i*8 +: 8];
            v = sgn ? {{56{w[7]}}, w} : {56'b0, w};
            if (m[i]) v = -v;
            s = s + v;
        end
        return s[OW-1:0];
    endfunction

    task automatic mon(input int w, input logic [3:0] rdy, input logic ov,
                       input logic [OW-1:0] o, input int ch, input bit sgn);
        logic [3:0]    full;
        logic [3:0]    exp_rdy;
        logic [OW-1:0] e;
        int            sz;
        full    = 4'((1 << ch) - 1);
        exp_rdy = ((out_ready || !ov) && ((in_valid & full) == full) && !rst) ? full : 4'b0;
        check($sformatf("in_ready%0d", w), rdy, exp_rdy);
        if (rst) begin
            case (w)
                0: exp_qa.delete();
                1: exp_qb.delete();
                default: exp_qc.delete();
            endcase
        end else begin
            if (ov && out_ready) begin
                case (w)
                    0: sz = exp_qa.size();
                    1: sz = exp_qb.size();
                    default: sz = exp_qc.size();
                endcase
                if (sz == 0) begin
                    check($sformatf("spurious_out%0d", w), 32'(ov), 32'd0);
                end else begin
                    case (w)
                        0: e = exp_qa.pop_front();
                        1: e = exp_qb.pop_front();
                        default: e = exp_qc.pop_front();
                    endcase
                    check($sformatf("out%0d", w), o, e);
                end
            end
            if (exp_rdy != 4'b0) begin
                e = model(dinp, sub_mask, ch, sgn);
                case (w)
                    0: exp_qa.push_back(e);
                    1: exp_qb.push_back(e);
                    default: exp_qc.push_back(e);
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, in_ready_a, ov_a, out_a, 4, 1'b0);
        mon(1, in_ready_b, ov_b, out_b, 4, 1'b1);
        mon(2, {1'b0, in_ready_c}, ov_c, out_c, 3, 1'b0);
        if (prev_stall) begin
            check("stall_hold", out_a, prev_out);
            check("stall_valid", ov_a, 1);
        end
        prev_stall = ov_a && !out_ready && !rst;
        prev_out   = out_a;
        if (ov_a && out_ready && !rst) n_out_a++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                out_ready = (bp_cnt % 5) >= 3;
                bp_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [31:0] d, input logic [3:0] v, input logic [3:0] m);
        @(posedge clk);
        #1;
        dinp     = d;
        in_valid = v;
        sub_mask = m;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_qa.size() + exp_qb.size() + exp_qc.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_qa.size() + exp_qb.size() + exp_qc.size(), 0);
        @(negedge clk);
    endtask

    task automatic expect_out(input int w, input string tag, input logic [OW-1:0] e);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 60) begin
            @(negedge clk);
            case (w)
                0: if (ov_a && out_ready) begin hit = 1'b1; check(tag, out_a, e); end
                1: if (ov_b && out_ready) begin hit = 1'b1; check(tag, out_b, e); end
                default: if (ov_c && out_ready) begin hit = 1'b1; check(tag, out_c, e); end
            endcase
            n++;
        end
        check({tag, "_seen"}, hit, 1);
    endtask

    initial begin
        int lat;
        int n0;
        int k;
        int guard;
        logic [3:0] rv;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid_a", ov_a, 0);
        check("rst_out_a", out_a, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_valid_c", ov_c, 0);

        // Nominal add and latency
        drive(32'h04030201, 4'hf, 4'h0);
        @(negedge clk);
        check("nom_ready", in_ready_a, 4'hf);
        drive(32'h0, 4'h0, 4'h0);
        lat = 1;
        @(negedge clk);
        while (!ov_a && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check("nom_lat_a", lat, 3);
        check("nom_out_a", out_a, 10);
        check("nom_valid_c", ov_c, 1);
        check("nom_out_c", out_c, 6);
        @(negedge clk);
        check("nom_cnt", cnt_a, 1);

        // Partial valid consumes nothing on the 4-channel instances
        n0 = n_out_a;
        for (int i = 0; i < 5; i++) begin
            drive(32'h11223344, 4'b0111, 4'h0);
            @(negedge clk);
            check("pv_ready", in_ready_a, 4'h0);
        end
        drive(32'h11223344, 4'hf, 4'h0);
        @(negedge clk);
        check("pv_go", in_ready_a, 4'hf);
        drive(32'h0, 4'h0, 4'h0);
        repeat (10) @(negedge clk);
        check("pv_one_out", n_out_a - n0, 1);
        drain();

        // Subtraction
        drive(32'hFF000000, 4'hf, 4'b1000);
        drive(32'h281E140A, 4'hf, 4'b0101);
        drive(32'h0, 4'h0, 4'h0);
        expect_out(0, "sub_neg", 11'h701);
        expect_out(0, "sub_mix", 11'd20);
        drain();

        // Signed and odd channel count
        drive(32'h80808080, 4'hf, 4'h0);
        drive(32'h00FFFFFF, 4'hf, 4'h0);
        drive(32'h0, 4'h0, 4'h0);
        expect_out(1, "signed_neg", 11'h600);
        expect_out(2, "odd_765", 11'd765);
        drain();

        // Backpressure stream from a clean counter
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        bp_cnt = 0;
        bp_on  = 1'b1;
        k = 1;
        guard = 0;
        while (k <= 20 && guard < 500) begin
            drive({4{8'(k)}}, 4'hf, 4'h0);
            @(negedge clk);
            if (in_ready_a == 4'hf) k++;
            guard++;
        end
        check("bp_all_sent", k, 21);
        drive(32'h0, 4'h0, 4'h0);
        drain();
        bp_on = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_cnt", cnt_a, 20);

        // Random traffic with random masks and output stalls
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0) ? 4'hf : 4'($urandom);
            @(posedge clk);
            #1;
            dinp      = $urandom;
            in_valid  = rv;
            sub_mask  = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        drain();

        // Reset with two results in flight
        drive(32'($urandom), 4'hf, 4'($urandom));
        drive(32'($urandom), 4'hf, 4'($urandom));
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 4'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid_a", ov_a, 0);
        check("mid_rst_out_a", out_a, 0);
        check("mid_rst_cnt_a", cnt_a, 0);
        check("mid_rst_valid_b", ov_b, 0);
        check("mid_rst_cnt_c", cnt_c, 0);
        n0 = n_out_a;
        repeat (10) @(negedge clk);
        check("mid_rst_no_stale", n_out_a - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
